// File: rtl/seq_bit_serializer_if.sv
// Handshake bundle between the serializer and its user: button/abort/switch
// inputs in, serial bit, strobe, LED and status outputs back.
interface seq_bit_serializer_if #(
    parameter int N = 8
);
    localparam int BW = $clog2(N);

    logic          start;
    logic          abort;
    logic [N-1:0]  data;
    logic          x_out;
    logic          x_valid;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  leds;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, data,
        input  x_out, x_valid, bit_idx, leds, busy, done
    );

    modport slave (
        input  start, abort, data,
        output x_out, x_valid, bit_idx, leds, busy, done
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Button-triggered serializer: captures a switch word on a start edge and
// plays it out once, one bit per DIV clocks, with a one-cycle valid strobe.
module seq_bit_serializer #(
    parameter int N         = 8,
    parameter int DIV       = 25000000,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_bit_serializer_if.slave   bus
);
    localparam int BW = $clog2(N);
    localparam int CW = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  sh_nx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] idx_q, idx_d;
    logic          x_out_q, x_out_d;
    logic          x_valid_q, x_valid_d;
    logic [N-1:0]  leds_q, leds_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          start_rise;

    // LED position tracks the data bit index, not the transmission index.
    function automatic logic [N-1:0] led_onehot(input logic [BW-1:0] idx);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[k] = MSB_FIRST ? (int'(idx) == N - 1 - k) : (int'(idx) == k);
        return r;
    endfunction

    function automatic logic head(input logic [N-1:0] v);
        return MSB_FIRST ? v[N-1] : v[0];
    endfunction

    assign sh_nx      = MSB_FIRST ? {sh_q[N-2:0], 1'b0} : {1'b0, sh_q[N-1:1]};
    assign start_rise = sync2_q & ~sync3_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        leds_d    = leds_q;

        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            x_out_d = 1'b0;
            leds_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state_d = LOAD;
                        sh_d    = bus.data;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    x_out_d   = head(sh_q);
                    leds_d    = led_onehot('0);
                    x_valid_d = 1'b1;
                end
                SHIFT: begin
                    if (cnt_q == CW'(DIV - 1)) begin
                        cnt_d = '0;
                        if (idx_q == BW'(N - 1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d     = idx_q + BW'(1);
                            sh_d      = sh_nx;
                            x_out_d   = head(sh_nx);
                            leds_d    = led_onehot(idx_q + BW'(1));
                            x_valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            leds_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            leds_q    <= leds_d;
            sync1_q   <= bus.start;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;
    assign bus.bit_idx = idx_q;
    assign bus.leds    = leds_q;
    assign bus.busy    = (state_q == LOAD) || (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: LSB-first and MSB-first instances
// driven side by side with N=8, DIV=4.
module tb_seq_bit_serializer;
    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] data;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int st_cyc   = 0;
    int done_cyc = 0;
    logic done_prev = 1'b0;

    logic       lq_x[$];
    logic [7:0] lq_led[$];
    logic [2:0] lq_idx[$];
    int         lq_cyc[$];
    logic       mq_x[$];
    logic [7:0] mq_led[$];

    seq_bit_serializer_if #(.N(8)) if_l ();
    seq_bit_serializer_if #(.N(8)) if_m ();

    assign if_l.start = start;
    assign if_l.abort = abort;
    assign if_l.data  = data;
    assign if_m.start = start;
    assign if_m.abort = abort;
    assign if_m.data  = data;

    seq_bit_serializer #(.N(8), .DIV(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .bus(if_l)
    );
    seq_bit_serializer #(.N(8), .DIV(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .bus(if_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if_l.x_valid === 1'b1) begin
            lq_x.push_back(if_l.x_out);
            lq_led.push_back(if_l.leds);
            lq_idx.push_back(if_l.bit_idx);
            lq_cyc.push_back(cyc);
        end
        if (if_m.x_valid === 1'b1) begin
            mq_x.push_back(if_m.x_out);
            mq_led.push_back(if_m.leds);
        end
        if (if_l.done === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (if_l.done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        lq_x.delete(); lq_led.delete(); lq_idx.delete(); lq_cyc.delete();
        mq_x.delete(); mq_led.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        start  = 1'b1;
        st_cyc = cyc;
        repeat (len) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int k = 0;
        while (lq_x.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_strobes_in_time"}, 32'(lq_x.size() >= n), 32'd1);
    endtask

    task automatic check_lsb(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        check({tag, "_count"}, 32'(lq_x.size()), 32'd8);
        if (lq_x.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                e = 8'h01 << i;
                check($sformatf("%s_x%0d", tag, i), 32'(lq_x[i]), 32'(exp[i]));
                check($sformatf("%s_led%0d", tag, i), 32'(lq_led[i]), 32'(e));
                check($sformatf("%s_idx%0d", tag, i), 32'(lq_idx[i]), 32'(i));
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i), 32'(lq_cyc[i] - lq_cyc[i-1]), 32'd4);
            end
        end
    endtask

    task automatic check_msb(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        check({tag, "_count"}, 32'(mq_x.size()), 32'd8);
        if (mq_x.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                e = 8'h80 >> i;
                check($sformatf("%s_x%0d", tag, i), 32'(mq_x[i]), 32'(exp[7-i]));
                check($sformatf("%s_led%0d", tag, i), 32'(mq_led[i]), 32'(e));
            end
        end
    endtask

    function automatic logic [31:0] outs_l();
        return 32'({if_l.x_out, if_l.x_valid, if_l.bit_idx, if_l.leds, if_l.busy, if_l.done});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic anynz;
        reset = 1'b0; start = 1'b0; abort = 1'b0; data = 8'h00;

        // Reset and idle quiet period
        tick(3);
        check("reset_outs_l", outs_l(), 32'd0);
        check("reset_outs_m", 32'({if_m.x_out, if_m.x_valid, if_m.leds, if_m.busy, if_m.done}), 32'd0);
        reset = 1'b1;
        anynz = 1'b0;
        repeat (50) begin
            @(negedge clk);
            #1;
            anynz |= (outs_l() != 0) | if_m.x_valid | if_m.busy | if_m.done | (|if_m.leds);
        end
        check("idle_quiet", 32'(anynz), 32'd0);
        check("idle_no_strobe", 32'(lq_x.size()), 32'd0);

        // Normal transmission, both bit orders
        clear_q();
        data = 8'hB4;
        pulse_start(10);
        wait_strobes("normal", 8, 100);
        tick(8);
        #1;
        check_lsb("normal", 8'hB4);
        check_msb("msb", 8'hB4);
        if (lq_cyc.size() == 8) begin
            check("first_latency", 32'(lq_cyc[0] - st_cyc), 32'd4);
            check("done_delay", 32'(done_cyc - lq_cyc[7]), 32'd4);
        end
        check("normal_done", 32'(if_l.done), 32'd1);
        check("normal_busy", 32'(if_l.busy), 32'd0);
        check("normal_hold_x", 32'(if_l.x_out), 32'd1);
        check("normal_hold_led", 32'(if_l.leds), 32'h80);
        check("msb_hold_led", 32'(if_m.leds), 32'h01);

        // Retrigger and data change during SHIFT are ignored
        clear_q();
        data = 8'hB4;
        pulse_start(2);
        wait_strobes("retrig_a", 2, 40);
        data = 8'hFF;
        pulse_start(2);
        wait_strobes("retrig_b", 8, 100);
        tick(20);
        check_lsb("retrig", 8'hB4);

        // Start after done sends the new word
        clear_q();
        pulse_start(2);
        wait_strobes("restart", 8, 100);
        tick(20);
        check_lsb("restart", 8'hFF);

        // Abort during the third bit
        clear_q();
        data = 8'hB4;
        pulse_start(2);
        wait_strobes("abort", 3, 60);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_outs", outs_l(), 32'd0);
        tick(60);
        check("abort_no_more", 32'(lq_x.size()), 32'd3);

        // Asynchronous reset mid-SHIFT
        clear_q();
        pulse_start(2);
        wait_strobes("areset", 2, 60);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("areset_outs", outs_l(), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(20);
        check("areset_no_more", 32'(lq_x.size()), 32'd2);
        clear_q();
        pulse_start(2);
        wait_strobes("post_reset", 8, 100);
        tick(20);
        check_lsb("post_reset", 8'hB4);

        // Start held high across done gives one transmission
        clear_q();
        data = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        wait_strobes("held", 8, 100);
        tick(40);
        check_lsb("held", 8'h3C);
        check("held_done", 32'(if_l.done), 32'd1);
        start = 1'b0;
        tick(5);

        // Glitch entirely between clock edges is never sampled
        clear_q();
        @(negedge clk);
        #2 start = 1'b1;
        #1 start = 1'b0;
        tick(60);
        check("glitch_between", 32'(lq_x.size()), 32'd0);

        // Glitch straddling one rising edge gives exactly one transmission
        clear_q();
        data = 8'h5A;
        @(negedge clk);
        #4 start = 1'b1;
        #2 start = 1'b0;
        wait_strobes("glitch_edge", 8, 100);
        tick(40);
        check_lsb("glitch_edge", 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the sequence detector FSM.
- On a button-initiated start, it captures a switch byte and presents the bits serially, one per bit-period, on x_out, with a one-cycle valid strobe.
- Also drives the bit-position LEDs.
- Replaces the free-running counter/8:1 mux arrangement so that a sequence is applied exactly once per start, from a known first bit.

Parameters:
- N, 8, data word width in bits; ≥2.
- DIV, 25000000, clk cycles per bit period; ≥2.
- MSB_FIRST, 0, 0 = send data[0] first; 1 = send data[N-1] first.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw asynchronous button; level, not synchronised externally.
- abort  input  1  synchronous, active-high; returns the block to IDLE.
- data  input  N  switch word; sampled only at load.
- x_out  output  1  current serial bit to the detector; held between strobes.
- x_valid  output  1  one-cycle strobe; the detector advances on it.
- bit_idx  output  clog2(N)  index of the bit now on x_out, counted in transmission order.
- leds  output  N  one-hot; leds[k] set while x_out carries data bit k.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  high in DONE until the next accepted start or abort.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - x_out, x_valid, bit_idx, leds, busy, done, the shift register and the tick counter are all 0.
  - Both start synchroniser flops are 0.
- Start synchronisation:
  - start passes through a 2-flop synchroniser.
  - start_rise = sync2 & ~sync3, using a third registered flop.
  - Only rising edges count; holding start high never retriggers.
- State machine: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - start_rise → LOAD.
    - Capture data into the shift register; tick counter = 0; bit_idx = 0; done = 0.
  - LOAD:
    - Exactly one cycle.
    - Drive x_out with the first bit (data[0], or data[N-1] if MSB_FIRST); set leds accordingly; busy = 1.
    - Pulse x_valid for this cycle.
    - → SHIFT.
  - SHIFT:
    - Tick counter increments each cycle.
    - At counter == DIV-1: counter wraps to 0.
      - If bit_idx == N-1 → DONE.
      - Otherwise bit_idx += 1; shift the register; drive the next bit on x_out; update leds; pulse x_valid.
  - DONE:
    - busy = 0; done = 1.
    - x_out and leds hold the last bit; x_valid = 0.
    - start_rise → LOAD, recapturing data.
- Bit timing: exactly N x_valid strobes per start, spaced exactly DIV cycles apart. The first strobe occurs 1 cycle after the FSM sees start_rise.
- Latency from start going high (stable) to the first x_valid is 4 clk cycles: sync (2), edge register (1), LOAD (1).
- start_rise in LOAD or SHIFT is ignored; the data register is not disturbed.
- abort:
  - Any state → IDLE next cycle.
  - x_out, leds, bit_idx, busy and done are cleared; no x_valid is generated.
  - abort has priority over start_rise in the same cycle.
- Changes on data after LOAD have no effect on the current transmission.
- bit_idx wrap: it never exceeds N-1; there is no wrap inside one transmission.
- An asynchronous reset mid-SHIFT returns to IDLE immediately. There is no partial strobe, and outputs clear within the reset assertion.

Test Plan:
- Reset test: N=8, DIV=4, reset low then high, no start.
  - All outputs 0; state IDLE for 50 cycles.
- Normal transmission: data=8'hB4, start high for 10 cycles.
  - First x_valid 4 cycles after start; strobes every 4 cycles.
  - x_out sequence on strobes is 0,0,1,0,1,1,0,1.
  - leds steps 01,02,…,80; bit_idx 0..7.
  - done rises 4 cycles after the 8th strobe; exactly 8 strobes total.
- MSB_FIRST=1 with data=8'hB4.
  - x_out sequence 1,0,1,1,0,1,0,0; leds 80,40,…,01.
- Ignored retrigger and data stability: second start pulse plus data=8'hFF applied during SHIFT.
  - Stream unchanged (still 8'hB4 bits); no extra strobes.
  - A start pulse after done restarts and sends 8'hFF (eight 1s).
- Abort and async reset mid-stream:
  - abort during the 3rd bit → IDLE next cycle; x_valid never asserts again; busy=0, done=0.
  - Repeat with reset pulled low mid-SHIFT → outputs 0 asynchronously; the next start sends a full 8 bits.
- Edge-only start: start held high continuously across done.
  - Exactly one transmission.
  - A glitch shorter than 1 clk between edges (bench drives asynchronously) yields at most one transmission.
